// File: rtl/debounced_bcd_counter.sv
// Up/down packed-BCD counter fed by debounced button levels; each rising
// edge of Up/Down/Clear is one step, with one-cycle carry/borrow wrap pulses.
module debounced_bcd_counter #(
  parameter int NumDigits = 2
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   UpIn,
  input  logic                   DownIn,
  input  logic                   ClearIn,
  output logic [4*NumDigits-1:0] BcdOut,
  output logic                   CarryOut,
  output logic                   BorrowOut
);

  localparam int W = 4 * NumDigits;

  // Ripple +1 across digits; MSB of the result is the wrap carry.
  function automatic logic [W:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int k = 0; k < NumDigits; k++) begin
      if (c) begin
        if (v[4*k +: 4] >= 4'd9) begin
          r[4*k +: 4] = 4'd0;
          c           = 1'b1;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] + 4'd1;
          c           = 1'b0;
        end
      end else begin
        r[4*k +: 4] = v[4*k +: 4];
      end
    end
    return {c, r};
  endfunction

  // Ripple -1 across digits; MSB of the result is the wrap borrow.
  // A non-BCD digit (unreachable from reset) is pulled back to 9.
  function automatic logic [W:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int k = 0; k < NumDigits; k++) begin
      if (b) begin
        if (v[4*k +: 4] == 4'd0) begin
          r[4*k +: 4] = 4'd9;
          b           = 1'b1;
        end else if (v[4*k +: 4] > 4'd9) begin
          r[4*k +: 4] = 4'd9;
          b           = 1'b0;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] - 4'd1;
          b           = 1'b0;
        end
      end else begin
        r[4*k +: 4] = v[4*k +: 4];
      end
    end
    return {b, r};
  endfunction

  logic [W-1:0] count_q, count_d;
  logic         carry_q, carry_d;
  logic         borrow_q, borrow_d;
  logic         up_prev_q, up_prev_d;
  logic         down_prev_q, down_prev_d;
  logic         clear_prev_q, clear_prev_d;
  logic         up_edge_s, down_edge_s, clear_edge_s;
  logic [W:0]   inc_res_s, dec_res_s;

  // Edge detection and prioritised next-count selection.
  always_comb begin
    up_edge_s    = UpIn & ~up_prev_q;
    down_edge_s  = DownIn & ~down_prev_q;
    clear_edge_s = ClearIn & ~clear_prev_q;
    inc_res_s    = bcd_inc(count_q);
    dec_res_s    = bcd_dec(count_q);

    up_prev_d    = UpIn;
    down_prev_d  = DownIn;
    clear_prev_d = ClearIn;
    count_d      = count_q;
    carry_d      = 1'b0;
    borrow_d     = 1'b0;

    if (clear_edge_s) begin
      count_d = {W{1'b0}};
    end else if (up_edge_s && down_edge_s) begin
      count_d = count_q;
    end else if (up_edge_s) begin
      count_d = inc_res_s[W-1:0];
      carry_d = inc_res_s[W];
    end else if (down_edge_s) begin
      count_d  = dec_res_s[W-1:0];
      borrow_d = dec_res_s[W];
    end else begin
      count_d = count_q;
    end
  end

  // State register; prev levels track the inputs even in reset so a held
  // button does not step when reset releases.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      count_q      <= {W{1'b0}};
      carry_q      <= 1'b0;
      borrow_q     <= 1'b0;
      up_prev_q    <= UpIn;
      down_prev_q  <= DownIn;
      clear_prev_q <= ClearIn;
    end else begin
      count_q      <= count_d;
      carry_q      <= carry_d;
      borrow_q     <= borrow_d;
      up_prev_q    <= up_prev_d;
      down_prev_q  <= down_prev_d;
      clear_prev_q <= clear_prev_d;
    end
  end

  assign BcdOut    = count_q;
  assign CarryOut  = carry_q;
  assign BorrowOut = borrow_q;

endmodule

// File: tb/tb_debounced_bcd_counter.sv
// Bench for debounced_bcd_counter: directed plan plus biased random walk,
// checked every cycle against an integer-arithmetic reference model.
module tb_debounced_bcd_counter;

  localparam int N   = 2;
  localparam int W   = 4 * N;
  localparam int MAX = 99;

  logic         Clk;
  logic         Reset;
  logic         UpIn, DownIn, ClearIn;
  logic [W-1:0] BcdOut;
  logic         CarryOut, BorrowOut;

  int errors = 0;
  int checks = 0;

  int m_cnt = 0;
  bit m_carry = 1'b0, m_borrow = 1'b0;
  bit m_up_p = 1'b0, m_dn_p = 1'b0, m_cl_p = 1'b0;

  debounced_bcd_counter #(.NumDigits(N)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .UpIn     (UpIn),
    .DownIn   (DownIn),
    .ClearIn  (ClearIn),
    .BcdOut   (BcdOut),
    .CarryOut (CarryOut),
    .BorrowOut(BorrowOut)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           t;
    t = v;
    for (int k = 0; k < N; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one clock, advance the model, compare all outputs.
  task automatic drive(input bit r, input bit u, input bit d, input bit c);
    bit ue, de, ce;
    Reset = r; UpIn = u; DownIn = d; ClearIn = c;
    @(posedge Clk);
    ue = u & !m_up_p; de = d & !m_dn_p; ce = c & !m_cl_p;
    m_up_p = u; m_dn_p = d; m_cl_p = c;
    m_carry = 1'b0; m_borrow = 1'b0;
    if (!r) m_cnt = 0;
    else if (ce) m_cnt = 0;
    else if (ue && de) m_cnt = m_cnt;
    else if (ue) begin
      m_carry = (m_cnt == MAX);
      m_cnt   = (m_cnt + 1) % (MAX + 1);
    end else if (de) begin
      m_borrow = (m_cnt == 0);
      m_cnt    = (m_cnt + MAX) % (MAX + 1);
    end
    #1;
    chk("bcd",    32'(BcdOut),    32'(to_bcd(m_cnt)));
    chk("carry",  32'(CarryOut),  32'(m_carry));
    chk("borrow", 32'(BorrowOut), 32'(m_borrow));
  endtask

  task automatic ups(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic clear_cnt();
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    Reset = 1'b0; UpIn = 1'b0; DownIn = 1'b0; ClearIn = 1'b0;

    // Button held through reset must not step.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      chk("reset_hold", 32'(BcdOut), 32'h00);
      chk("reset_carry", 32'(CarryOut | BorrowOut), 32'h0);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);

    // Three pulses, high 3 / low 2.
    for (int p = 0; p < 3; p++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      chk("single_step", 32'(BcdOut), 32'(p + 1));
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      chk("held_no_step", 32'(BcdOut), 32'(p + 1));
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
    end

    ups(5);
    chk("at_08", 32'(BcdOut), 32'h08);
    ups(1);
    chk("at_09", 32'(BcdOut), 32'h09);
    ups(1);
    chk("ripple_10", 32'(BcdOut), 32'h10);
    ups(89);
    chk("at_99", 32'(BcdOut), 32'h99);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("wrap_00", 32'(BcdOut), 32'h00);
    chk("carry_pulse", 32'(CarryOut), 32'h1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("carry_gone", 32'(CarryOut), 32'h0);

    // Borrow wrap and digit borrow.
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("borrow_99", 32'(BcdOut), 32'h99);
    chk("borrow_pulse", 32'(BorrowOut), 32'h1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("borrow_gone", 32'(BorrowOut), 32'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("down_98", 32'(BcdOut), 32'h98);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    clear_cnt();
    ups(10);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("down_09", 32'(BcdOut), 32'h09);
    drive(1'b1, 1'b0, 1'b0, 1'b0);

    // Priority cases at 42.
    clear_cnt();
    ups(42);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    chk("updown_hold", 32'(BcdOut), 32'h42);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    chk("clear_wins", 32'(BcdOut), 32'h00);
    chk("clear_no_pulse", 32'(CarryOut | BorrowOut), 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);

    // Reset on the same edge as an up rise at 57.
    ups(57);
    chk("at_57", 32'(BcdOut), 32'h57);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("reset_mid", 32'(BcdOut), 32'h00);
    chk("reset_mid_carry", 32'(CarryOut), 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("post_reset_held", 32'(BcdOut), 32'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("post_reset_step", 32'(BcdOut), 32'h01);

    // Biased random walk so both wraps are exercised.
    for (int s = 0; s < 12; s++) begin
      bit up_bias;
      up_bias = s[0];
      for (int i = 0; i < 200; i++) begin
        bit r, u, d, c;
        r = ($urandom_range(99) != 0);
        c = ($urandom_range(39) == 0);
        if (up_bias) begin
          u = $urandom_range(1);
          d = ($urandom_range(9) == 0);
        end else begin
          d = $urandom_range(1);
          u = ($urandom_range(9) == 0);
        end
        drive(r, u, d, c);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
